// File: rtl/wm_pkg.sv
// -----------------------------------------------------------------------------
// wm_pkg
// Shared definitions for the washing-machine controller slice.
//   wm_state_e  : programme state codes (Off, FillWater, Wash, Drain, Rinse,
//                 Spin, Done); code 3'b111 is never produced.
//   CNT_W       : width of the phase timer counter.
//   *_T_DEF     : default phase durations in clock cycles.
//   is_active() : true for the five phases in which the machine is busy.
// -----------------------------------------------------------------------------
package wm_pkg;

   typedef enum logic [2:0] {
      OFF        = 3'b000,
      FILL_WATER = 3'b001,
      WASH       = 3'b010,
      DRAIN      = 3'b011,
      RINSE      = 3'b100,
      SPIN       = 3'b101,
      DONE       = 3'b110
   } wm_state_e;

   localparam int CNT_W = 4;

   localparam int FILL_T_DEF  = 4;
   localparam int WASH_T_DEF  = 8;
   localparam int DRAIN_T_DEF = 4;
   localparam int RINSE_T_DEF = 6;
   localparam int SPIN_T_DEF  = 8;

   // The machine counts as busy (and the timer runs) only in these phases.
   function automatic logic is_active(input wm_state_e s);
      return (s == FILL_WATER) || (s == WASH) || (s == DRAIN) ||
             (s == RINSE) || (s == SPIN);
   endfunction

endpackage

// File: rtl/wm_fsm.sv
// -----------------------------------------------------------------------------
// wm_fsm
// Programme sequencer: Off -> FillWater -> Wash -> Drain -> Rinse -> Spin ->
// Done -> Off, advancing from an active phase only on the timer's terminal.
// Optional build macro WM_START_EDGE_EN: when defined, Off is left only on a
// rising edge of start_button; otherwise start is level-sensitive.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start_button in   start request, only looked at in Off
//   pause_button in   freezes progress in active phases, blocks start in Off
//   terminal     in   last cycle of the current phase (from the timer)
//   enable       out  timer enable: active phase and not paused
//   phase_len    out  duration of the current phase in cycles
//   out          out  busy flag, registered
// -----------------------------------------------------------------------------
module wm_fsm
   import wm_pkg::*;
#(
   parameter int FILL_T  = FILL_T_DEF,
   parameter int WASH_T  = WASH_T_DEF,
   parameter int DRAIN_T = DRAIN_T_DEF,
   parameter int RINSE_T = RINSE_T_DEF,
   parameter int SPIN_T  = SPIN_T_DEF
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start_button,
   input  logic             pause_button,
   input  logic             terminal,
   output logic             enable,
   output logic [CNT_W:0]   phase_len,
   output logic             out
);

   wm_state_e state;
   wm_state_e next_state;
   logic      start_ok;

`ifdef WM_START_EDGE_EN
   logic start_prev;

   // Remember last cycle's button level so only a 0->1 change starts a run;
   // a button held through Done therefore does not restart the machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_prev <= 1'b0;
      end else begin
         start_prev <= start_button;
      end
   end

   assign start_ok = start_button && !start_prev;
`else
   assign start_ok = start_button;
`endif

   assign enable = is_active(state) && !pause_button;

   // Pick the duration of whichever phase we are in; outside the active
   // phases the length is irrelevant because the timer is not enabled.
   always_comb begin
      phase_len = '0;
      case (state)
         FILL_WATER: phase_len = (CNT_W+1)'(FILL_T);
         WASH:       phase_len = (CNT_W+1)'(WASH_T);
         DRAIN:      phase_len = (CNT_W+1)'(DRAIN_T);
         RINSE:      phase_len = (CNT_W+1)'(RINSE_T);
         SPIN:       phase_len = (CNT_W+1)'(SPIN_T);
         default:    phase_len = '0;
      endcase
   end

   // Each state either holds or moves to its successor. Terminal already
   // folds in the pause, so a paused phase holds automatically. Done always
   // returns to Off regardless of the buttons.
   always_comb begin
      next_state = state;
      case (state)
         OFF:        if (start_ok && !pause_button) next_state = FILL_WATER;
         FILL_WATER: if (terminal) next_state = WASH;
         WASH:       if (terminal) next_state = DRAIN;
         DRAIN:      if (terminal) next_state = RINSE;
         RINSE:      if (terminal) next_state = SPIN;
         SPIN:       if (terminal) next_state = DONE;
         DONE:       next_state = OFF;
         default:    next_state = OFF;
      endcase
   end

   // State register. The busy flag is loaded from next_state so it rises in
   // the same cycle state becomes FillWater and drops as state becomes Done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= OFF;
         out   <= 1'b0;
      end else begin
         state <= next_state;
         out   <= is_active(next_state);
      end
   end

endmodule

// File: rtl/wm_timer.sv
// -----------------------------------------------------------------------------
// wm_timer
// Phase timer: counts un-paused cycles of the current phase and flags the
// last one so the sequencer can advance.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears the counter
//   enable    in   phase active and not paused
//   phase_len in   length of the current phase in cycles (1..16)
//   terminal  out  high on the last enabled cycle of the phase
// -----------------------------------------------------------------------------
module wm_timer
   import wm_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W:0]   phase_len,
   output logic             terminal
);

   localparam logic [CNT_W:0] LenOne = (CNT_W+1)'(1);

   logic [CNT_W-1:0] counter;

   // Terminal count is compared one bit wider so a 16-cycle phase ends at 15
   // without the counter ever needing to hold 16.
   assign terminal = enable && ({1'b0, counter} == (phase_len - LenOne));

   // The counter clears on the same edge the phase advances, so it starts each
   // phase at zero and sits at zero in Off and Done where enable is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
      end else if (terminal) begin
         counter <= '0;
      end else if (enable) begin
         counter <= counter + CNT_W'(1);
      end
   end

endmodule

// File: rtl/washing_machine_ctrl.sv
// -----------------------------------------------------------------------------
// washing_machine_ctrl
// Top-level washing-machine sequencer: sequencer fsm_1 plus phase timer T_1.
// Optional build macro WM_START_EDGE_EN (see wm_fsm) makes start edge-triggered.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start_button in   start request (level)
//   pause_button in   pause request (level), high freezes progress
//   out          out  busy: high in FillWater, Wash, Drain, Rinse and Spin
// -----------------------------------------------------------------------------
module washing_machine_ctrl
   import wm_pkg::*;
#(
   parameter int FILL_T  = FILL_T_DEF,
   parameter int WASH_T  = WASH_T_DEF,
   parameter int DRAIN_T = DRAIN_T_DEF,
   parameter int RINSE_T = RINSE_T_DEF,
   parameter int SPIN_T  = SPIN_T_DEF
)
(
   input  logic clk,
   input  logic reset,
   input  logic start_button,
   input  logic pause_button,
   output logic out
);

   logic             enable;
   logic             terminal;
   logic [CNT_W:0]   phase_len;

   wm_fsm #(
      .FILL_T  (FILL_T),
      .WASH_T  (WASH_T),
      .DRAIN_T (DRAIN_T),
      .RINSE_T (RINSE_T),
      .SPIN_T  (SPIN_T)
   ) fsm_1 (
      .clk          (clk),
      .reset        (reset),
      .start_button (start_button),
      .pause_button (pause_button),
      .terminal     (terminal),
      .enable       (enable),
      .phase_len    (phase_len),
      .out          (out)
   );

   wm_timer T_1 (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .phase_len (phase_len),
      .terminal  (terminal)
   );

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// -----------------------------------------------------------------------------
// tb_washing_machine_ctrl
// Drives washing_machine_ctrl with directed and random button/reset patterns
// and compares state, next_state, phase counter and busy flag against a
// phase-level reference model (phase index plus elapsed cycles in phase).
// -----------------------------------------------------------------------------
module tb_washing_machine_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_button = 1'b0;
   logic pause_button = 1'b0;
   logic out;

   int total = 0;
   int bad = 0;

   // Phase numbering of the model: 0 Off, 1..5 the timed phases in programme
   // order, 6 Done. These match the published state codes.
   int phaseLen [1:5] = '{4, 8, 4, 6, 8};

   int modelPhase = 0;
   int modelCnt = 0;
   bit modelPrevStart = 1'b0;

   washing_machine_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .start_button (start_button),
      .pause_button (pause_button),
      .out          (out)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour for one clock edge with the given inputs.
   task automatic modelStep(input bit r, input bit s, input bit p,
                            output int nPhase, output int nCnt, output bit nPrev);
      bit startOk;
`ifdef WM_START_EDGE_EN
      startOk = s && !modelPrevStart;
`else
      startOk = s;
`endif
      nPhase = modelPhase;
      nCnt   = modelCnt;
      nPrev  = s;
      if (r) begin
         nPhase = 0;
         nCnt   = 0;
         nPrev  = 1'b0;
      end else if (modelPhase == 0) begin
         if (startOk && !p) nPhase = 1;
      end else if (modelPhase == 6) begin
         nPhase = 0;
      end else if (!p) begin
         if (modelCnt + 1 == phaseLen[modelPhase]) begin
            nPhase = modelPhase + 1;
            nCnt   = 0;
         end else begin
            nCnt = modelCnt + 1;
         end
      end
   endtask

   // Apply one cycle of inputs, check the combinational next state before the
   // edge, then check registered outputs just after it.
   task automatic applyStimulus(input bit r, input bit s, input bit p);
      int nPhase;
      int nCnt;
      bit nPrev;
      reset        = r;
      start_button = s;
      pause_button = p;
      #1;
      modelStep(r, s, p, nPhase, nCnt, nPrev);
      if (!r) checkOutput("next_state", int'(dut.fsm_1.next_state), nPhase);
      @(posedge clk);
      modelPhase     = nPhase;
      modelCnt       = nCnt;
      modelPrevStart = nPrev;
      #1;
      checkOutput("state", int'(dut.fsm_1.state), modelPhase);
      checkOutput("counter", int'(dut.T_1.counter), modelCnt);
      checkOutput("out", int'(out), (modelPhase >= 1 && modelPhase <= 5) ? 1 : 0);
   endtask

   initial begin
      int busy;
      int washLen;
      int pauseLeft;
      bit p;

      $display("[TB] starting");

      // Reset for one cycle, then idle with no start.
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

      // Start held: full programme, Done, Off, then restart.
      busy = 0;
      repeat (31) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (out === 1'b1) busy++;
      end
      checkOutput("busy_len", busy, 30);
      checkOutput("done_after_30", int'(dut.fsm_1.state), 6);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      // Pause for 6 cycles in Wash at counter 3: Wash lasts 14 cycles.
      applyStimulus(1'b1, 1'b0, 1'b0);
      washLen   = 0;
      pauseLeft = 6;
      for (int i = 0; i < 40; i++) begin
         p = (modelPhase == 2) && (modelCnt == 3) && (pauseLeft > 0);
         if (p) pauseLeft--;
         applyStimulus(1'b0, 1'b1, p);
         if (int'(dut.fsm_1.state) == 2) washLen++;
      end
      checkOutput("wash_len", washLen, 14);

      // Start pulsed once: programme completes and machine stays in Off.
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (40) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_pulse", int'(dut.fsm_1.state), 0);

      // Reset in the middle of Rinse aborts without passing through Done.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40 && !(modelPhase == 4 && modelCnt == 2); i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      checkOutput("rinse_before_reset", int'(dut.fsm_1.state), 4);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("state_after_reset", int'(dut.fsm_1.state), 0);

      // Random buttons with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 4) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
